// File: rtl/switchover_clock_selector_if.sv
// Candidate clock inputs and reconstructed clock output of the switchover selector.
// Latency: none, wires only.
// Backpressure: none, these are free-running clock-like signals.
interface switchover_clock_selector_if;
  logic first_clock;
  logic second_clock;
  logic clock_out;

  // Source side: drives the candidate clocks and observes the reconstructed clock.
  modport master (
    output first_clock,
    output second_clock,
    input  clock_out
  );

  // Selector side: samples the candidates and drives the reconstructed clock.
  modport slave (
    input  first_clock,
    input  second_clock,
    output clock_out
  );
endinterface

// File: rtl/switchover_clock_selector.sv
// Reconstructs the running candidate clock (second preferred, first as fallback) on a registered output.
// Latency: STAGES+1 reference cycles from a candidate edge to the matching clock_out edge.
// Backpressure: none; a stopped candidate is detected by timeout and the output idles low.
module switchover_clock_selector #(
  parameter int STAGES  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  switchover_clock_selector_if.slave    bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  logic [STAGES-1:0] first_sh;
  logic [STAGES-1:0] second_sh;
  logic              first_prev;
  logic              second_prev;
  logic [CW-1:0]     first_cnt;
  logic [CW-1:0]     second_cnt;
  state_t            state_q;
  state_t            state_d;
  state_t            target;
  logic              out_q;
  logic              out_d;

  logic first_sync;
  logic second_sync;
  logic first_rise;
  logic second_rise;
  logic first_fall;
  logic second_fall;
  logic first_active;
  logic second_active;

  assign first_sync    = first_sh[STAGES-1];
  assign second_sync   = second_sh[STAGES-1];
  assign first_rise    = first_sync & ~first_prev;
  assign second_rise   = second_sync & ~second_prev;
  assign first_fall    = ~first_sync & first_prev;
  assign second_fall   = ~second_sync & second_prev;
  assign first_active  = (first_cnt < CNT_MAX);
  assign second_active = (second_cnt < CNT_MAX);
  assign bus.clock_out = out_q;

  // Synchronize both asynchronous candidates and keep one previous sample for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_sh    <= '0;
      second_sh   <= '0;
      first_prev  <= 1'b0;
      second_prev <= 1'b0;
    end else begin
      first_sh    <= {first_sh[STAGES-2:0], bus.first_clock};
      second_sh   <= {second_sh[STAGES-2:0], bus.second_clock};
      first_prev  <= first_sync;
      second_prev <= second_sync;
    end
  end

  // Activity timers: cleared by a sampled rising edge, saturating at TIMEOUT (= stopped).
  always_ff @(posedge clock) begin
    if (reset) begin
      first_cnt  <= CNT_MAX;
      second_cnt <= CNT_MAX;
    end else begin
      if (first_rise)
        first_cnt <= '0;
      else if (first_cnt < CNT_MAX)
        first_cnt <= first_cnt + 1'b1;
      if (second_rise)
        second_cnt <= '0;
      else if (second_cnt < CNT_MAX)
        second_cnt <= second_cnt + 1'b1;
    end
  end

  // Preferred source given current activity: second wins, first is the fallback.
  always_comb begin
    target = NONE;
    if (second_active)
      target = SECOND;
    else if (first_active)
      target = FIRST;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset)
      state_q <= NONE;
    else
      state_q <= state_d;
  end

  // Switch only while the output is low and the new source has just fallen, so the
  // new source's first output phase is a complete low phase followed by a full high phase.
  // A target that returns to the current state simply never satisfies the switch test.
  always_comb begin
    state_d = state_q;
    if ((target != state_q) && !out_q) begin
      case (target)
        NONE:    state_d = NONE;
        FIRST:   if (first_fall)  state_d = FIRST;
        SECOND:  if (second_fall) state_d = SECOND;
        default: state_d = NONE;
      endcase
    end
  end

  // Follow the selected source; a source that timed out is forced low.
  always_comb begin
    out_d = 1'b0;
    case (state_d)
      FIRST:   out_d = first_sync & first_active;
      SECOND:  out_d = second_sync & second_active;
      default: out_d = 1'b0;
    endcase
  end

  // Registered output keeps clock_out glitch-free.
  always_ff @(posedge clock) begin
    if (reset)
      out_q <= 1'b0;
    else
      out_q <= out_d;
  end

endmodule

// File: tb/tb_switchover_clock_selector.sv
`timescale 1ns/100ps
// Directed bench for the switchover clock selector: idle, acquisition, priority switch, loss of sources, reset.
// Latency: output edges are logged on the falling reference edge and analysed per window.
// Backpressure: none; every wait is bounded by a fixed time or cycle budget.
module tb_switchover_clock_selector;
  localparam int STAGES  = 2;
  localparam int TIMEOUT = 64;

  logic clock;
  logic reset;
  logic first_en;
  logic second_en;

  switchover_clock_selector_if sel_if ();

  switchover_clock_selector #(
    .STAGES (STAGES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sel_if.slave)
  );

  int tests;
  int fails;

  realtime edge_t[$];
  logic    edge_v[$];
  logic    mon_last;

  int n_rise, min_hi, max_hi, min_lo, max_lo, min_per, max_per;

  initial begin
    clock = 1'b0;
    forever #0.5 clock = ~clock;
  end

  // First candidate: 40 ns period; stops low when disabled.
  initial begin
    sel_if.first_clock = 1'b0;
    forever begin
      wait (first_en);
      sel_if.first_clock = 1'b1;
      #20;
      sel_if.first_clock = 1'b0;
      #20;
    end
  end

  // Second candidate: 12 ns period; stops low when disabled.
  initial begin
    sel_if.second_clock = 1'b0;
    forever begin
      wait (second_en);
      sel_if.second_clock = 1'b1;
      #6;
      sel_if.second_clock = 1'b0;
      #6;
    end
  end

  // Edge log of clock_out, sampled away from the active reference edge.
  initial mon_last = 1'b0;
  always @(negedge clock) begin
    if (sel_if.clock_out !== mon_last) begin
      edge_t.push_back($realtime);
      edge_v.push_back(sel_if.clock_out);
      mon_last = sel_if.clock_out;
    end
  end

  // Phase and period statistics over complete phases logged from index k0 on.
  task automatic analyze(input int k0);
    int d;
    int last_rise_idx;
    n_rise = 0; min_hi = 9999; max_hi = -1; min_lo = 9999; max_lo = -1;
    min_per = 9999; max_per = -1;
    last_rise_idx = -1;
    for (int i = k0; i < edge_t.size(); i++) begin
      if (edge_v[i] === 1'b1) begin
        n_rise++;
        if (last_rise_idx >= 0) begin
          d = $rtoi(edge_t[i] - edge_t[last_rise_idx] + 0.5);
          if (d < min_per) min_per = d;
          if (d > max_per) max_per = d;
        end
        last_rise_idx = i;
      end
      if (i + 1 < edge_t.size()) begin
        d = $rtoi(edge_t[i+1] - edge_t[i] + 0.5);
        if (edge_v[i] === 1'b1) begin
          if (d < min_hi) min_hi = d;
          if (d > max_hi) max_hi = d;
        end else begin
          if (d < min_lo) min_lo = d;
          if (d > max_lo) max_lo = d;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int lo, input int hi);
    logic ok;
    ok = (obs >= lo) && (obs <= hi);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  initial begin
    int k0;
    int waited;
    realtime t0;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    first_en = 1'b0;
    second_en = 1'b0;

    // 1. Idle: reset held with both candidates stopped, then released.
    #100;
    chk("reset_out", int'(sel_if.clock_out), 0, 0);
    @(negedge clock);
    reset = 1'b0;
    k0 = edge_t.size();
    #200;
    chk("idle_edges", edge_t.size() - k0, 0, 0);
    chk("idle_out", int'(sel_if.clock_out), 0, 0);

    // 2. Start first: acquisition time, then 40 ns period with 20 ns high phases.
    k0 = edge_t.size();
    t0 = $realtime;
    first_en = 1'b1;
    waited = 0;
    while (edge_t.size() == k0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (edge_t.size() > k0)
      chk("acquire_time", $rtoi(edge_t[k0] - t0 + 0.5), 1, TIMEOUT + STAGES + 1);
    else
      chk("acquire_time", 9999, 1, TIMEOUT + STAGES + 1);
    #60;
    k0 = edge_t.size();
    #200;
    analyze(k0);
    chk("first_per_min", min_per, 39, 41);
    chk("first_per_max", max_per, 39, 41);
    chk("first_hi_min", min_hi, 19, 21);
    chk("first_hi_max", max_hi, 19, 21);

    // 3. Start second while first runs: no short phase during the switch, then 12 ns period.
    k0 = edge_t.size();
    second_en = 1'b1;
    #150;
    analyze(k0);
    chk("sw12_hi_min", min_hi, 5, 9999);
    chk("sw12_lo_min", min_lo, 5, 9999);
    k0 = edge_t.size();
    #120;
    analyze(k0);
    chk("second_per_min", min_per, 11, 13);
    chk("second_per_max", max_per, 11, 13);
    chk("second_hi_min", min_hi, 5, 7);
    chk("second_hi_max", max_hi, 5, 7);

    // 4. Stop first while second is selected: output undisturbed.
    k0 = edge_t.size();
    first_en = 1'b0;
    #200;
    analyze(k0);
    chk("stop1_per_min", min_per, 11, 13);
    chk("stop1_per_max", max_per, 11, 13);
    chk("stop1_rises", n_rise, 15, 18);

    // 5. Restart first, then stop second: fall back to 40 ns without short phases.
    first_en = 1'b1;
    #100;
    k0 = edge_t.size();
    second_en = 1'b0;
    #250;
    analyze(k0);
    chk("sw21_hi_min", min_hi, 5, 9999);
    chk("sw21_lo_min", min_lo, 5, 9999);
    k0 = edge_t.size();
    #200;
    analyze(k0);
    chk("back_per_min", min_per, 39, 41);
    chk("back_per_max", max_per, 39, 41);

    // 6. One-cycle reset while the output is high, then reacquire first.
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (sel_if.clock_out !== 1'b1 && waited < 100);
    chk("pre_reset_high", int'(sel_if.clock_out), 1, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset_out", int'(sel_if.clock_out), 0, 0);
    reset = 1'b0;
    #150;
    k0 = edge_t.size();
    #200;
    analyze(k0);
    chk("reacq_per_min", min_per, 39, 41);
    chk("reacq_per_max", max_per, 39, 41);
    chk("reacq_hi_min", min_hi, 19, 21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
